// File: rtl/hc595_scan_driver.sv
// Multiplexed 7-segment scan driver for a daisy-chained 74HC595 pair: per digit it
// shifts {select, segments} MSB-first on a divided clock, pulses the latch, then dwells.
module hc595_scan_driver #(
   parameter int NUM_DIGITS     = 6,
   parameter int SEG_WIDTH      = 8,
   parameter int SEL_WIDTH      = 8,
   parameter int CLK_DIV        = 2,
   parameter int DWELL_CYCLES   = 4,
   parameter int SEL_ACTIVE_LOW = 1,
   parameter int SEG_ACTIVE_LOW = 1,
   localparam int CUR_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
   input  logic                            s_clk,
   input  logic                            s_reset,
   input  logic                            enable,
   input  logic [NUM_DIGITS*SEG_WIDTH-1:0] data_in,
   input  logic [NUM_DIGITS-1:0]           digit_en,
   output logic                            data_out,
   output logic                            data_clock,
   output logic                            latch_out,
   output logic                            busy,
   output logic                            frame_done,
   output logic [CUR_W-1:0]                cur_digit
);

   localparam int W     = SEL_WIDTH + SEG_WIDTH;
   localparam int BIT_W = $clog2(W);
   localparam int CNT_W = 16;

   localparam logic [CNT_W-1:0]     DIV_LAST   = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0]     DWELL_LAST = CNT_W'((DWELL_CYCLES > 0) ? DWELL_CYCLES - 1 : 0);
   localparam logic [CUR_W-1:0]     LAST_DIGIT = CUR_W'(NUM_DIGITS - 1);
   localparam logic [SEG_WIDTH-1:0] BLANK      = {SEG_WIDTH{SEG_ACTIVE_LOW != 0}};

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_LOAD     = 3'd1;
   localparam logic [2:0] ST_SHIFT_LO = 3'd2;
   localparam logic [2:0] ST_SHIFT_HI = 3'd3;
   localparam logic [2:0] ST_LATCH    = 3'd4;
   localparam logic [2:0] ST_DWELL    = 3'd5;

   logic [2:0]                      r_state;
   logic [CNT_W-1:0]                r_divCnt;
   logic [BIT_W-1:0]                r_bitCnt;
   logic [W-1:0]                    r_shift;
   logic [CUR_W-1:0]                r_curDigit;
   logic [NUM_DIGITS*SEG_WIDTH-1:0] r_dataSnap;
   logic [NUM_DIGITS-1:0]           r_enSnap;
   logic                            r_dataOut;
   logic                            r_dataClock;
   logic                            r_latch;
   logic                            r_busy;
   logic                            r_frameDone;

   logic [2:0]           w_stateNext;
   logic [CNT_W-1:0]     w_divNext;
   logic [BIT_W-1:0]     w_bitNext;
   logic [W-1:0]         w_shiftNext;
   logic [CUR_W-1:0]     w_digitNext;
   logic                 w_snap;
   logic                 w_endDigit;
   logic                 w_frameDoneNext;
   logic [SEL_WIDTH-1:0] w_selOneHot;
   logic [SEL_WIDTH-1:0] w_sel;
   logic [SEG_WIDTH-1:0] w_seg;
   logic [W-1:0]         w_word;

   // Word for the current digit, always built from the frame snapshot
   always_comb begin
      w_selOneHot = SEL_WIDTH'(1) << r_curDigit;
      w_sel       = (SEL_ACTIVE_LOW != 0) ? ~w_selOneHot : w_selOneHot;
      w_seg       = r_enSnap[r_curDigit] ? r_dataSnap[r_curDigit*SEG_WIDTH +: SEG_WIDTH] : BLANK;
      w_word      = {w_sel, w_seg};
   end

   always_comb begin
      w_stateNext     = r_state;
      w_divNext       = r_divCnt;
      w_bitNext       = r_bitCnt;
      w_shiftNext     = r_shift;
      w_digitNext     = r_curDigit;
      w_snap          = 1'b0;
      w_endDigit      = 1'b0;
      w_frameDoneNext = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (enable) begin
               w_snap      = 1'b1;
               w_digitNext = '0;
               w_stateNext = ST_LOAD;
            end
         end
         ST_LOAD: begin
            w_shiftNext = w_word;
            w_bitNext   = BIT_W'(W - 1);
            w_divNext   = '0;
            w_stateNext = ST_SHIFT_LO;
         end
         ST_SHIFT_LO: begin
            if (r_divCnt == DIV_LAST) begin
               w_divNext   = '0;
               w_stateNext = ST_SHIFT_HI;
            end else begin
               w_divNext = r_divCnt + CNT_W'(1);
            end
         end
         ST_SHIFT_HI: begin
            if (r_divCnt == DIV_LAST) begin
               w_divNext = '0;
               if (r_bitCnt == '0) begin
                  w_stateNext = ST_LATCH;
               end else begin
                  w_shiftNext = {r_shift[W-2:0], 1'b0};
                  w_bitNext   = r_bitCnt - BIT_W'(1);
                  w_stateNext = ST_SHIFT_LO;
               end
            end else begin
               w_divNext = r_divCnt + CNT_W'(1);
            end
         end
         ST_LATCH: begin
            if (r_divCnt == DIV_LAST) begin
               w_divNext = '0;
               if (DWELL_CYCLES == 0) w_endDigit  = 1'b1;
               else                   w_stateNext = ST_DWELL;
            end else begin
               w_divNext = r_divCnt + CNT_W'(1);
            end
         end
         ST_DWELL: begin
            if (r_divCnt == DWELL_LAST) begin
               w_divNext  = '0;
               w_endDigit = 1'b1;
            end else begin
               w_divNext = r_divCnt + CNT_W'(1);
            end
         end
         default: w_stateNext = ST_IDLE;
      endcase

      // Frame end re-snapshots the inputs so a running scan stays coherent per frame
      if (w_endDigit) begin
         if (r_curDigit != LAST_DIGIT) begin
            w_digitNext = r_curDigit + CUR_W'(1);
            w_stateNext = ST_LOAD;
         end else begin
            w_frameDoneNext = 1'b1;
            w_digitNext     = '0;
            if (enable) begin
               w_snap      = 1'b1;
               w_stateNext = ST_LOAD;
            end else begin
               w_stateNext = ST_IDLE;
            end
         end
      end
   end

   // Outputs are registered from the next state so they line up with r_state glitch-free
   always_ff @(posedge s_clk) begin
      if (!s_reset) begin
         r_state     <= ST_IDLE;
         r_divCnt    <= '0;
         r_bitCnt    <= '0;
         r_shift     <= '0;
         r_curDigit  <= '0;
         r_dataSnap  <= '0;
         r_enSnap    <= '0;
         r_dataOut   <= 1'b0;
         r_dataClock <= 1'b0;
         r_latch     <= 1'b0;
         r_busy      <= 1'b0;
         r_frameDone <= 1'b0;
      end else begin
         r_state    <= w_stateNext;
         r_divCnt   <= w_divNext;
         r_bitCnt   <= w_bitNext;
         r_shift    <= w_shiftNext;
         r_curDigit <= w_digitNext;
         if (w_snap) begin
            r_dataSnap <= data_in;
            r_enSnap   <= digit_en;
         end
         r_dataOut   <= ((w_stateNext == ST_SHIFT_LO) || (w_stateNext == ST_SHIFT_HI)) & w_shiftNext[W-1];
         r_dataClock <= (w_stateNext == ST_SHIFT_HI);
         r_latch     <= (w_stateNext == ST_LATCH);
         r_busy      <= (w_stateNext != ST_IDLE);
         r_frameDone <= w_frameDoneNext;
      end
   end

   assign data_out   = r_dataOut;
   assign data_clock = r_dataClock;
   assign latch_out  = r_latch;
   assign busy       = r_busy;
   assign frame_done = r_frameDone;
   assign cur_digit  = r_curDigit;

endmodule

// File: tb/tb_hc595_scan_driver.sv
// Bench for hc595_scan_driver: models the external 74HC595 chain to capture latched
// words and checks them against the digit word rules, for default and alternate parameters.
module tb_hc595_scan_driver;

   localparam int ND  = 6;
   localparam int CD  = 2;
   localparam int DW  = 4;
   localparam int W   = 16;
   localparam int P   = 1 + 2*CD*W + CD + DW;
   localparam int AND_ = 4;
   localparam int AW  = 12;
   localparam int AP  = 1 + 2*1*AW + 1 + 0;

   logic        sClk = 1'b0;
   logic        sReset;
   logic        enable;
   logic [47:0] dataIn;
   logic [5:0]  digitEn;
   logic        dataOut, dataClock, latchOut, busy, frameDone;
   logic [2:0]  curDigit;

   logic        altEnable;
   logic [31:0] altDataIn;
   logic [3:0]  altDigitEn;
   logic        altDataOut, altDataClock, altLatchOut, altBusy, altFrameDone;
   logic [1:0]  altCurDigit;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int frameStart = 0;

   always #5 sClk = ~sClk;

   hc595_scan_driver dut (
      .s_clk(sClk), .s_reset(sReset), .enable(enable), .data_in(dataIn), .digit_en(digitEn),
      .data_out(dataOut), .data_clock(dataClock), .latch_out(latchOut), .busy(busy),
      .frame_done(frameDone), .cur_digit(curDigit)
   );

   hc595_scan_driver #(
      .NUM_DIGITS(4), .SEG_WIDTH(8), .SEL_WIDTH(4), .CLK_DIV(1), .DWELL_CYCLES(0),
      .SEL_ACTIVE_LOW(0), .SEG_ACTIVE_LOW(1)
   ) altDut (
      .s_clk(sClk), .s_reset(sReset), .enable(altEnable), .data_in(altDataIn), .digit_en(altDigitEn),
      .data_out(altDataOut), .data_clock(altDataClock), .latch_out(altLatchOut), .busy(altBusy),
      .frame_done(altFrameDone), .cur_digit(altCurDigit)
   );

   always @(posedge sClk) cyc <= cyc + 1;

   // External shift/storage register pair, sampled mid-cycle
   logic [15:0] chain595 = '0;
   logic        prevClk = 1'b0, prevLatch = 1'b0, prevData = 1'b0;
   int          latchLen = 0;
   int          dataViol = 0, overlapViol = 0;
   logic [15:0] latchWords[$];
   int          latchCycs[$];
   int          latchLens[$];
   int          doneCycs[$];

   always @(negedge sClk) begin
      if (dataClock && !prevClk) chain595 <= {chain595[14:0], dataOut};
      if (latchOut && !prevLatch) begin
         latchWords.push_back(chain595);
         latchCycs.push_back(cyc);
         latchLen <= 1;
      end else if (latchOut) begin
         latchLen <= latchLen + 1;
      end
      if (prevLatch && !latchOut) latchLens.push_back(latchLen);
      if (frameDone) doneCycs.push_back(cyc);
      if ((dataOut !== prevData) && dataClock) dataViol <= dataViol + 1;
      if (latchOut && dataClock) overlapViol <= overlapViol + 1;
      prevClk   <= dataClock;
      prevLatch <= latchOut;
      prevData  <= dataOut;
   end

   logic [15:0] altChain = '0;
   logic        altPrevClk = 1'b0, altPrevLatch = 1'b0;
   int          altOverlapViol = 0;
   logic [11:0] altWords[$];
   int          altCycs[$];
   int          altDoneCycs[$];

   always @(negedge sClk) begin
      if (altDataClock && !altPrevClk) altChain <= {altChain[14:0], altDataOut};
      if (altLatchOut && !altPrevLatch) begin
         altWords.push_back(altChain[11:0]);
         altCycs.push_back(cyc);
      end
      if (altFrameDone) altDoneCycs.push_back(cyc);
      if (altLatchOut && altDataClock) altOverlapViol <= altOverlapViol + 1;
      altPrevClk   <= altDataClock;
      altPrevLatch <= altLatchOut;
   end

   task automatic tick();
      @(negedge sClk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] expWord(input int d, input logic [47:0] data, input logic [5:0] en);
      logic [7:0] sel;
      logic [7:0] seg;
      sel    = 8'hFF;
      sel[d] = 1'b0;
      seg    = en[d] ? data[d*8 +: 8] : 8'hFF;
      return {sel, seg};
   endfunction

   function automatic logic [11:0] altExpWord(input int d, input logic [31:0] data, input logic [3:0] en);
      logic [3:0] sel;
      logic [7:0] seg;
      sel    = 4'h0;
      sel[d] = 1'b1;
      seg    = en[d] ? data[d*8 +: 8] : 8'hFF;
      return {sel, seg};
   endfunction

   function automatic logic [47:0] rand48();
      return 48'({$urandom(), $urandom()});
   endfunction

   task automatic clearQueues();
      latchWords.delete();
      latchCycs.delete();
      latchLens.delete();
      doneCycs.delete();
   endtask

   task automatic waitBusy(output int startCyc);
      int n = 0;
      while (!busy && n < 100) begin
         tick();
         n++;
      end
      checkOutput("busy_rise", busy, 1'b1);
      startCyc = cyc;
   endtask

   // Run until the frame ends, changing inputs once changeAt words have latched
   task automatic applyStimulus(input int changeAt, input logic [47:0] nd, input logic [5:0] ne,
                                input bit dropEn, output bit timedOut);
      bit changed = 1'b0;
      int n = 0;
      timedOut = 1'b0;
      while (doneCycs.size() == 0) begin
         tick();
         n++;
         if (!changed && latchWords.size() >= changeAt) begin
            dataIn  = nd;
            digitEn = ne;
            if (dropEn) enable = 1'b0;
            changed = 1'b1;
         end
         if (n > 2*ND*P) begin
            timedOut = 1'b1;
            break;
         end
      end
   endtask

   task automatic checkFrame(input logic [47:0] d, input logic [5:0] e, input bit timedOut);
      checkOutput("frame_timeout", timedOut, 1'b0);
      checkOutput("latch_count", latchWords.size(), ND);
      for (int i = 0; i < ND; i++) begin
         if (i < latchWords.size()) begin
            checkOutput($sformatf("word_d%0d", i), latchWords[i], expWord(i, d, e));
            checkOutput($sformatf("latch_cycle_d%0d", i), latchCycs[i] - frameStart, i*P + 1 + 2*CD*W);
         end
         if (i < latchLens.size())
            checkOutput($sformatf("latch_len_d%0d", i), latchLens[i], CD);
      end
      checkOutput("done_count", doneCycs.size(), 1);
      if (doneCycs.size() > 0) begin
         checkOutput("done_cycle", doneCycs[0] - frameStart, ND*P);
         frameStart = doneCycs[0];
      end
      clearQueues();
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [47:0] dA, dB, dC, dN;
      logic [5:0]  eC, eN;
      bit          to;
      int          n;
      int          nLatch;
      int          altStart;

      sReset = 1'b0; enable = 1'b0; dataIn = '0; digitEn = '0;
      altEnable = 1'b0; altDataIn = '0; altDigitEn = '0;
      repeat (3) tick();
      checkOutput("reset_outputs", {dataOut, dataClock, latchOut, busy, frameDone}, 5'b0);
      checkOutput("reset_digit", curDigit, 3'd0);
      checkOutput("reset_alt_busy", altBusy, 1'b0);

      dA = 48'h0000_0000_003F;
      dB = 48'h6D66_4F5B_063F;
      dataIn = dA; digitEn = 6'h3F; enable = 1'b1; sReset = 1'b1;
      waitBusy(frameStart);
      checkOutput("first_digit", curDigit, 3'd0);
      applyStimulus(1, dB, 6'h3F, 1'b0, to);
      checkFrame(dA, 6'h3F, to);

      dC = rand48();
      applyStimulus(0, dC, 6'b111101, 1'b0, to);
      checkFrame(dB, 6'h3F, to);

      dN = rand48(); eN = 6'($urandom());
      applyStimulus(2, dN, eN, 1'b0, to);
      checkFrame(dC, 6'b111101, to);
      dC = dN; eC = eN;

      for (int i = 0; i < 2; i++) begin
         dN = rand48(); eN = 6'($urandom());
         applyStimulus(3, dN, eN, 1'b0, to);
         checkFrame(dC, eC, to);
         dC = dN; eC = eN;
      end

      applyStimulus(3, rand48(), 6'($urandom()), 1'b1, to);
      checkFrame(dC, eC, to);
      checkOutput("idle_busy", busy, 1'b0);
      tick();
      checkOutput("idle_frame_done_pulse", frameDone, 1'b0);
      checkOutput("idle_digit", curDigit, 3'd0);
      repeat (20) tick();
      checkOutput("idle_no_latch", latchWords.size(), 0);

      dC = rand48(); eC = 6'($urandom());
      dataIn = dC; digitEn = eC; enable = 1'b1;
      waitBusy(frameStart);
      n = 0;
      while (!(curDigit == 3'd3 && dataClock) && n < 1000) begin
         tick();
         n++;
      end
      checkOutput("reach_d3_shift_hi", n < 1000, 1'b1);
      nLatch = latchWords.size();
      checkOutput("latches_before_reset", nLatch, 3);
      sReset = 1'b0;
      tick();
      checkOutput("midshift_reset_outputs", {dataOut, dataClock, latchOut, busy, frameDone}, 5'b0);
      checkOutput("midshift_reset_digit", curDigit, 3'd0);
      tick();
      checkOutput("no_latch_after_reset", latchWords.size(), nLatch);
      clearQueues();
      sReset = 1'b1;
      waitBusy(frameStart);
      applyStimulus(6, rand48(), 6'($urandom()), 1'b1, to);
      checkFrame(dC, eC, to);
      tick();
      checkOutput("post_reset_idle", busy, 1'b0);

      altDataIn = $urandom(); altDigitEn = 4'($urandom());
      altEnable = 1'b1;
      n = 0;
      while (!altBusy && n < 100) begin
         tick();
         n++;
      end
      checkOutput("alt_busy_rise", altBusy, 1'b1);
      altStart = cyc;
      altEnable = 1'b0;
      n = 0;
      while (altDoneCycs.size() == 0 && n < 4*AP*2) begin
         tick();
         n++;
      end
      checkOutput("alt_latch_count", altWords.size(), AND_);
      for (int i = 0; i < AND_; i++) begin
         if (i < altWords.size()) begin
            checkOutput($sformatf("alt_word_d%0d", i), altWords[i], altExpWord(i, altDataIn, altDigitEn));
            checkOutput($sformatf("alt_latch_cycle_d%0d", i), altCycs[i] - altStart, i*AP + AP - 1);
         end
      end
      checkOutput("alt_done_count", altDoneCycs.size(), 1);
      if (altDoneCycs.size() > 0)
         checkOutput("alt_done_cycle", altDoneCycs[0] - altStart, AND_*AP);
      checkOutput("alt_idle_busy", altBusy, 1'b0);

      checkOutput("data_change_while_clk_high", dataViol, 0);
      checkOutput("latch_overlaps_clk", overlapViol, 0);
      checkOutput("alt_latch_overlaps_clk", altOverlapViol, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
